// File: rtl/ysyx_23060236_rd_xbar.sv
// rtl/ysyx_23060236_rd_xbar.sv - AXI4-Lite read crossbar, one master to CLINT/SoC with decode-error responder
module ysyx_23060236_rd_xbar #(
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
   parameter logic [31:0] DEV_BASE   = 32'h8000_0000,
   parameter logic [31:0] DEV_MASK   = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] m_araddr,
   input  logic        m_arvalid,
   output logic        m_arready,
   output logic [31:0] m_rdata,
   output logic [1:0]  m_rresp,
   output logic        m_rvalid,
   input  logic        m_rready,
   output logic [31:0] c_araddr,
   output logic        c_arvalid,
   input  logic        c_arready,
   input  logic [31:0] c_rdata,
   input  logic [1:0]  c_rresp,
   input  logic        c_rvalid,
   output logic        c_rready,
   output logic [31:0] s_araddr,
   output logic        s_arvalid,
   input  logic        s_arready,
   input  logic [31:0] s_rdata,
   input  logic [1:0]  s_rresp,
   input  logic        s_rvalid,
   output logic        s_rready
);

   typedef enum logic [1:0] {IDLE, AR, R, ERR} state_t;

   localparam logic [1:0] SEL_SOC   = 2'd0;
   localparam logic [1:0] SEL_CLINT = 2'd1;
   localparam logic [1:0] SEL_ERR   = 2'd2;

   state_t      state, state_n;
   logic [31:0] addr_q;
   logic [1:0]  sel_q;
   logic [1:0]  sel_d;

   // Address decode of the incoming request; CLINT wins over the device window
   always_comb begin
      sel_d = SEL_ERR;
      if ((m_araddr & CLINT_MASK) == CLINT_BASE)
         sel_d = SEL_CLINT;
      else if ((m_araddr & DEV_MASK) == DEV_BASE)
         sel_d = SEL_SOC;
   end

   // State, latched address and target; address/target only captured on acceptance
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         addr_q <= 32'h0;
         sel_q  <= SEL_SOC;
      end else begin
         state <= state_n;
         if (state == IDLE && m_arvalid) begin
            addr_q <= m_araddr;
            sel_q  <= sel_d;
         end
      end
   end

   // Next state and all channel outputs; slave AR driven only from registered state
   always_comb begin
      state_n   = state;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = 32'h0;
      m_rresp   = 2'b00;
      c_araddr  = addr_q;
      s_araddr  = addr_q;
      c_arvalid = 1'b0;
      s_arvalid = 1'b0;
      c_rready  = 1'b0;
      s_rready  = 1'b0;
      case (state)
         IDLE: begin
            m_arready = 1'b1;
            if (m_arvalid)
               state_n = (sel_d == SEL_ERR) ? ERR : AR;
         end
         AR: begin
            if (sel_q == SEL_CLINT) begin
               c_arvalid = 1'b1;
               if (c_arready) state_n = R;
            end else if (sel_q == SEL_SOC) begin
               s_arvalid = 1'b1;
               if (s_arready) state_n = R;
            end
         end
         R: begin
            if (sel_q == SEL_CLINT) begin
               m_rvalid = c_rvalid;
               m_rdata  = c_rdata;
               m_rresp  = c_rresp;
               c_rready = m_rready;
               if (c_rvalid && m_rready) state_n = IDLE;
            end else if (sel_q == SEL_SOC) begin
               m_rvalid = s_rvalid;
               m_rdata  = s_rdata;
               m_rresp  = s_rresp;
               s_rready = m_rready;
               if (s_rvalid && m_rready) state_n = IDLE;
            end
         end
         ERR: begin
            m_rvalid = 1'b1;
            m_rresp  = 2'b11;
            if (m_rready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/ysyx_23060236_rd_xbar.md
Name: ysyx_23060236_rd_xbar

Overview:
AXI4-Lite read-channel crossbar, 1 master to 2 slaves, sitting directly upstream of the CLINT timer slave. It takes the LSU/IFU-arbiter read requests and routes each one by address to the CLINT port, the SoC/device port, or an internal decode-error responder. The R response is returned to the master. Only one transaction is in flight at any time.

Parameters:
CLINT_BASE, 32'h0200_0000, CLINT region base; match when (addr & CLINT_MASK) == CLINT_BASE
CLINT_MASK, 32'hFFFF_0000, CLINT region compare mask
DEV_BASE, 32'h8000_0000, SoC/device region base; match when (addr & DEV_MASK) == DEV_BASE
DEV_MASK, 32'h8000_0000, SoC/device region compare mask

Ports:
clock  in  1  single system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (asserted when 0)
m_araddr  in  32  master read address
m_arvalid  in  1  master AR valid
m_arready  out  1  master AR ready
m_rdata  out  32  master read data
m_rresp  out  2  master read response
m_rvalid  out  1  master R valid
m_rready  in  1  master R ready
c_araddr  out  32  CLINT read address
c_arvalid  out  1  CLINT AR valid
c_arready  in  1  CLINT AR ready
c_rdata  in  32  CLINT read data
c_rresp  in  2  CLINT read response
c_rvalid  in  1  CLINT R valid
c_rready  out  1  CLINT R ready
s_araddr  out  32  SoC read address
s_arvalid  out  1  SoC AR valid
s_arready  in  1  SoC AR ready
s_rdata  in  32  SoC read data
s_rresp  in  2  SoC read response
s_rvalid  in  1  SoC R valid
s_rready  out  1  SoC R ready

Behaviour:
- FSM states: IDLE, AR, R, ERR. Registers: state, addr_q[31:0], sel_q[1:0] (0 = SoC, 1 = CLINT, 2 = error).
- Reset (reset == 0 at posedge): state = IDLE, addr_q = 0, sel_q = 0. Outputs after reset: m_arready = 1, m_rvalid = 0, m_rdata = 0, m_rresp = 0. All slave-side valid/ready signals are 0.
- IDLE: m_arready = 1. On m_arvalid: latch addr_q = m_araddr and decode sel_q. CLINT match has priority over DEV match; neither match gives error. Next state is AR for SoC/CLINT targets, ERR for the error target.
- AR: m_arready = 0. The selected slave's arvalid = 1 and its araddr = addr_q; the unselected slave sees arvalid = 0 and araddr = addr_q. Stay until the selected arready = 1, then go to R. arvalid must stay asserted until the handshake; no combinational path from m_arvalid to the slave arvalid.
- R: combinational pass-through from the selected slave: m_rvalid, m_rdata and m_rresp follow it, and the selected rready = m_rready. The unselected rready = 0. On selected rvalid & m_rready, return to IDLE.
- ERR: m_rvalid = 1, m_rdata = 0, m_rresp = 2'b11 (DECERR). Held until m_rready, then IDLE. No slave is touched.
- Outside R/ERR: m_rvalid = 0, m_rdata = 32'h0, m_rresp = 2'b00.
- Minimum latency, zero-wait slave: AR accepted at cycle 0, slave AR handshake at cycle 1, R handshake possible at cycle 2. A new AR can be accepted the cycle after the R handshake, so there is a 1-cycle IDLE bubble.
- A spurious slave rvalid while in IDLE/AR, or from the unselected slave, is ignored: its rready = 0 and it is not forwarded.
- Reset asserted mid-transaction (AR or R): FSM returns to IDLE and the in-flight transaction is abandoned. Slaves are reset by the same reset net.
- Address decode uses the full 32 bits. addr_q is held stable from IDLE exit until return to IDLE.

Test Plan:
- Reset held low 3 cycles with m_arvalid = 1 -> m_arready = 1, m_rvalid = 0, c_arvalid = s_arvalid = 0; no request is latched until the cycle reset = 1.
- Read 0x0200_0000 to CLINT, zero-wait, c_rdata = 0x0000_0123 -> c_arvalid at cycle 1 with c_araddr = 0x0200_0000; m_rdata = 0x123, m_rresp = 0 at cycle 2; s_arvalid stays 0.
- Read 0x8000_0010, SoC arready delayed 3 cycles, rvalid delayed 4 more -> s_arvalid held 4 cycles; m_rvalid only when s_rvalid; data and resp passed through unchanged.
- Read 0x1000_0000 (unmapped) -> m_rvalid = 1, m_rresp = 2'b11, m_rdata = 0 from the cycle after acceptance; no slave arvalid ever asserted.
- Master backpressure: m_rready = 0 for 5 cycles during CLINT R -> c_rready = 0 and state stays R; on m_rready = 1 the transaction completes, and a back-to-back 0x0200_0004 read is accepted the next cycle.
- Reset pulsed low while in R -> IDLE next cycle, m_rvalid = 0, m_arready = 1.
